gnr_sim_controller: RTL and testbench
=====================================

GNR_SIM_CONTROLLER -- requirements
Module: gnr_sim_controller

Interface
REQ-001 The block SHALL expose parameter STEP_W, default 16, giving the width of the step counter and the num_steps request.
REQ-002 The block SHALL expose parameter CNT_W, default 16, giving the width of each ones counter.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-low reset.
REQ-005 Port: start  input  1  run request, sampled only in IDLE.
REQ-006 Port: num_steps  input  STEP_W  number of update steps in the run, latched on accepted start.
REQ-007 Port: init_value  input  1  initial node state, latched on accepted start.
REQ-008 Port: node_s0  input  1  downstream node s0 output (adenyl cyclase s0).
REQ-009 Port: node_s1  input  1  downstream node s1 output (adenyl cyclase s1).
REQ-010 Port: reset_nos  output  1  node re-initialise strobe.
REQ-011 Port: init_state  output  1  latched init_value, driven to the nodes.
REQ-012 Port: start_s0, start_s1  output  1 each  node update strobes.
REQ-013 Port: busy  output  1  high in every state other than IDLE.
REQ-014 Port: done  output  1  one-cycle completion pulse.
REQ-015 Port: step_count  output  STEP_W  number of steps completed in the current or last run.
REQ-016 Port: ones_s0, ones_s1  output  CNT_W each  count of sampled steps with node_s0 / node_s1 high.

Function
REQ-017 The FSM SHALL have exactly five states: IDLE, INIT, RUN, SAMPLE, DONE.
REQ-018 IDLE with start=1 SHALL latch num_steps and init_value, then go to INIT; start in any other state SHALL be ignored.
REQ-019 INIT SHALL:
- assert reset_nos for exactly one cycle;
- clear step_count, ones_s0 and ones_s1;
- then go to DONE if the latched num_steps is 0, else to RUN.
REQ-020 RUN SHALL assert start_s0 and start_s1 together for exactly one cycle, then go to SAMPLE.
REQ-021 SAMPLE SHALL:
- add node_s0 and node_s1 to their ones counters;
- increment step_count;
- go to DONE if the incremented step_count equals num_steps, else to RUN.
REQ-022 DONE SHALL assert done for one cycle, then go to IDLE.
REQ-023 reset_nos, start_s0, start_s1 and done SHALL be registered outputs that are never high in the same cycle.
REQ-024 Each step SHALL take 2 cycles; start accepted at edge t SHALL give reset_nos high in cycle t+1 and done high in cycle t+2+2N, where N is num_steps.
REQ-025 Ones counters SHALL saturate at all-ones and SHALL NOT wrap.
REQ-026 step_count SHALL reach num_steps exactly; num_steps of all-ones SHALL run 2^STEP_W-1 steps with no wrap.
REQ-027 step_count, ones_s0, ones_s1 and init_state SHALL hold after done until the next accepted start.
REQ-028 start held high continuously SHALL begin a new run on the cycle after DONE returns to IDLE.

Reset
REQ-029 rst low SHALL immediately, with no clock edge needed, force:
- the FSM to IDLE;
- reset_nos, start_s0, start_s1, init_state, busy and done to 0;
- step_count, ones_s0 and ones_s1 to 0.
REQ-030 rst asserted mid-run SHALL abort the run with no done pulse; the first start after rst rises SHALL begin a fresh run.

Configuration
REQ-031 With macro GNR_CTRL_PAUSE_EN defined, the block SHALL add input port pause (1 bit), with this behaviour:
- pause=1 in RUN SHALL hold the FSM in RUN with start_s0 and start_s1 low;
- the strobes SHALL resume on the first cycle with pause=0;
- pause SHALL have no effect in any other state.
REQ-032 Without GNR_CTRL_PAUSE_EN, the pause port SHALL NOT exist and RUN SHALL always last exactly one cycle.

Verification
REQ-033 Basic run: num_steps=3, init_value=1, node_s0=node_s1=1 throughout -> reset_nos high 1 cycle; 3 start pulses spaced 2 cycles apart; done 8 cycles after start; step_count=3; ones_s0=ones_s1=3.
REQ-034 Zero steps: num_steps=0 -> reset_nos pulse followed by done with no start_s0/start_s1 pulse; all counters 0.
REQ-035 Saturation: CNT_W=2, num_steps=6, node_s0=1, node_s1 alternating 1,0 per step -> ones_s0=3 (saturated), ones_s1=3.
REQ-036 Abort: rst low during the 2nd RUN of a 5-step run -> outputs 0 in the same cycle, no done; a new start with num_steps=1 then completes normally with step_count=1.
REQ-037 Ignored start: start pulsed during SAMPLE of a 4-step run -> num_steps and init_value latches unchanged; done only once.
REQ-038 Pause (GNR_CTRL_PAUSE_EN defined): pause=1 for 5 cycles during the 1st RUN of a 2-step run -> done delayed by exactly 5 cycles; no strobe pulse while paused.

Source files
------------

// File: rtl/gnr_sim_controller.sv
// gnr_sim_controller: sequences node re-init, paced update strobes and ones counting for a gene regulatory network simulation run.
// Ports:
//   clk, rst (async, active-low)
//   start, num_steps, init_value: run request; the step count and initial value are latched when start is accepted in IDLE.
//   node_s0, node_s1: node outputs, sampled once per step.
//   reset_nos, init_state, start_s0, start_s1: node control signals.
//   busy, done, step_count, ones_s0, ones_s1: run status and results.
// Optional macro GNR_CTRL_PAUSE_EN adds an input, pause. While pause is high, the run stays in RUN and no update strobe is issued.
module gnr_sim_controller #(
  parameter int STEP_W = 16,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [STEP_W-1:0] num_steps,
  input  logic              init_value,
  input  logic              node_s0,
  input  logic              node_s1,
`ifdef GNR_CTRL_PAUSE_EN
  input  logic              pause,
`endif
  output logic              reset_nos,
  output logic              init_state,
  output logic              start_s0,
  output logic              start_s1,
  output logic              busy,
  output logic              done,
  output logic [STEP_W-1:0] step_count,
  output logic [CNT_W-1:0]  ones_s0,
  output logic [CNT_W-1:0]  ones_s1
);
  localparam logic [2:0] IDLE = 3'd0, INIT = 3'd1, RUN = 3'd2, SAMPLE = 3'd3, DONE = 3'd4;
  localparam logic [STEP_W-1:0] STEP_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  logic [2:0] state;
  logic [STEP_W-1:0] steps;
  logic [STEP_W-1:0] step_nxt;
  logic hold;
`ifdef GNR_CTRL_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif
  assign step_nxt = step_count + STEP_ONE;
  assign busy = state != IDLE;
  // The strobes are registered. pause is sampled on the edge that would launch a strobe.
  // A strobe is therefore withheld for every cycle in which pause was high at that edge.
  // In RUN, the FSM moves on only after a strobe has actually gone out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      steps <= '0;
      init_state <= 1'b0;
      reset_nos <= 1'b0;
      start_s0 <= 1'b0;
      start_s1 <= 1'b0;
      done <= 1'b0;
      step_count <= '0;
      ones_s0 <= '0;
      ones_s1 <= '0;
    end else begin
      reset_nos <= 1'b0;
      start_s0 <= 1'b0;
      start_s1 <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          steps <= num_steps;
          init_state <= init_value;
          reset_nos <= 1'b1;
          state <= INIT;
        end
        INIT: begin
          step_count <= '0;
          ones_s0 <= '0;
          ones_s1 <= '0;
          if (steps == '0) begin
            done <= 1'b1;
            state <= DONE;
          end else begin
            start_s0 <= !hold;
            start_s1 <= !hold;
            state <= RUN;
          end
        end
        RUN: if (start_s0) state <= SAMPLE;
        else begin
          start_s0 <= !hold;
          start_s1 <= !hold;
        end
        SAMPLE: begin
          ones_s0 <= (node_s0 && !(&ones_s0)) ? ones_s0 + CNT_ONE : ones_s0;
          ones_s1 <= (node_s1 && !(&ones_s1)) ? ones_s1 + CNT_ONE : ones_s1;
          step_count <= step_nxt;
          if (step_nxt == steps) begin
            done <= 1'b1;
            state <= DONE;
          end else begin
            start_s0 <= !hold;
            start_s1 <= !hold;
            state <= RUN;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gnr_sim_controller.sv
// tb_gnr_sim_controller: randomized self-checking bench for gnr_sim_controller against a cycle-schedule reference model.
module tb_gnr_sim_controller;
  logic clk = 0, rst = 0, start = 0, init_value = 0, node_s0 = 0, node_s1 = 0;
  logic [3:0] num_steps = 0;
`ifdef GNR_CTRL_PAUSE_EN
  logic pause = 0;
`endif
  logic reset_nos, init_state, start_s0, start_s1, busy, done;
  logic [3:0] step_count;
  logic [1:0] ones_s0, ones_s1;
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  gnr_sim_controller #(.STEP_W(4), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .start(start), .num_steps(num_steps), .init_value(init_value),
    .node_s0(node_s0), .node_s1(node_s1),
`ifdef GNR_CTRL_PAUSE_EN
    .pause(pause),
`endif
    .reset_nos(reset_nos), .init_state(init_state), .start_s0(start_s0), .start_s1(start_s1),
    .busy(busy), .done(done), .step_count(step_count), .ones_s0(ones_s0), .ones_s1(ones_s1)
  );

  task automatic check(string tag, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Reference model of one run: start is accepted at edge t, and cycle c is the cycle after edge t+c-1.
  // reset_nos is high in cycle 1.
  // Step k strobes in cycle 2+2k (plus the pause delay p) and samples the nodes in the next cycle.
  // done is high in cycle 2+2N+p.
  // mode 0 drives random node values, mode 1 holds both nodes high, and mode 2 holds s0 high while s1 alternates 1,0.
  // Junk start requests are issued throughout the run and must be ignored.
  task automatic run(int n, bit iv, int mode, int p);
    int last, s0, s1, smp;
    bit strobe;
    s0 = 0;
    s1 = 0;
    num_steps = 4'(n);
    init_value = iv;
    start = 1;
    last = (n == 0) ? 2 : 2 + 2 * n + p;
    @(posedge clk);
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      num_steps = 4'($urandom);
      init_value = 1'($urandom);
`ifdef GNR_CTRL_PAUSE_EN
      pause = c <= p;
`endif
      strobe = 0;
      smp = -1;
      for (int k = 0; k < n; k++) begin
        if (c == 2 + 2 * k + p) strobe = 1;
        if (c == 3 + 2 * k + p) smp = k;
      end
      node_s0 = (mode == 0) ? 1'($urandom) : 1'b1;
      node_s1 = (mode == 0) ? 1'($urandom) : (mode == 1) ? 1'b1 : (smp >= 0 && smp % 2 == 0);
      if (smp >= 0) begin
        s0 += int'(node_s0);
        s1 += int'(node_s1);
      end
      check("reset_nos", int'(reset_nos), int'(c == 1));
      check("start_s0", int'(start_s0), int'(strobe));
      check("start_s1", int'(start_s1), int'(strobe));
      check("done", int'(done), int'(c == last));
      check("busy_run", int'(busy), 1);
    end
    @(negedge clk);
    start = 0;
`ifdef GNR_CTRL_PAUSE_EN
    pause = 0;
`endif
    check("busy_idle", int'(busy), 0);
    check("done_idle", int'(done), 0);
    check("step_count", int'(step_count), n);
    check("ones_s0", int'(ones_s0), (s0 > 3) ? 3 : s0);
    check("ones_s1", int'(ones_s1), (s1 > 3) ? 3 : s1);
    check("init_state", int'(init_state), int'(iv));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_step", int'(step_count), 0);
    check("rst_ones", int'(ones_s0) + int'(ones_s1), 0);
    rst = 1;
    @(negedge clk);
    run(3, 1, 1, 0);
    run(0, 0, 0, 0);
    run(6, 1, 2, 0);
    run(15, 0, 1, 0);
    run(4, 1, 0, 0);
    for (int i = 0; i < 8; i++) run($urandom_range(0, 7), 1'($urandom), 0, 0);
`ifdef GNR_CTRL_PAUSE_EN
    run(2, 1, 0, 5);
    run(3, 0, 0, 2);
`endif
    // Abort in the 2nd RUN of a 5-step run, then restart with 1 step.
    num_steps = 5;
    init_value = 1;
    start = 1;
    @(posedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 0;
    end
    check("abort_strobe", int'(start_s0), 1);
    #1 rst = 0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_strobes", int'(start_s0) + int'(start_s1) + int'(reset_nos), 0);
    check("abort_init", int'(init_state), 0);
    check("abort_step", int'(step_count), 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("abort_nodone", int'(done), 0);
    end
    rst = 1;
    @(negedge clk);
    run(1, 0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
